// File: rtl/blpix_pkg.sv
// Shared constants and helpers for the blpixgain pixel gain/saturation stage.
package blpix_pkg;
  localparam int NCH_DEF = 10;
  localparam int IW_DEF  = 10;
  localparam int OW_DEF  = 8;
  localparam int GW_DEF  = 2;
  localparam int CW_DEF  = 16;
  localparam int MAXW    = 64;
  localparam int PCW     = 7;

  function automatic logic [PCW-1:0] popcount(input logic [MAXW-1:0] v);
    logic [PCW-1:0] n;
    n = '0;
    for (int i = 0; i < MAXW; i++) n = n + PCW'(v[i]);
    return n;
  endfunction

  // Ones at every bit position >= lo; a sample fits only if these bits are clear.
  function automatic logic [MAXW-1:0] clip_mask(input int lo);
    return {MAXW{1'b1}} << lo;
  endfunction
endpackage

// File: rtl/blpixgain_if.sv
// Pixel tap stream plus frame-sync controls and saturation statistics.
interface blpixgain_if import blpix_pkg::*; #(
  parameter int NCH = NCH_DEF,
  parameter int IW  = IW_DEF,
  parameter int OW  = OW_DEF,
  parameter int GW  = GW_DEF,
  parameter int CW  = CW_DEF
);
  logic              tv;
  logic [GW-1:0]     gsel;
  logic              rnd_en;
  logic              vin;
  logic [NCH*IW-1:0] din;
  logic              vout;
  logic [NCH*OW-1:0] dout;
  logic [NCH-1:0]    sat;
  logic [GW-1:0]     gsel_act;
  logic [CW-1:0]     satcnt;
  logic              satcnt_vld;

  modport master (output tv, gsel, rnd_en, vin, din,
                  input  vout, dout, sat, gsel_act, satcnt, satcnt_vld);
  modport slave  (input  tv, gsel, rnd_en, vin, din,
                  output vout, dout, sat, gsel_act, satcnt, satcnt_vld);
endinterface

// File: rtl/blpixsat.sv
// One tap: right shift by sh, optional half-LSB round, clip to OW bits, registered.
module blpixsat import blpix_pkg::*; #(
  parameter int IW = IW_DEF,
  parameter int OW = OW_DEF,
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          init,
  input  logic          en,
  input  logic [IW-1:0] din,
  input  logic [SW-1:0] sh,
  input  logic          rnd,
  output logic [OW-1:0] dout,
  output logic          sat
);
  logic [OW-1:0] res, dout_d, dout_q;
  logic [OW:0]   sum;
  logic          hi, rbit, sat_d, sat_q;

  always_comb begin
    // truncation is lossless whenever hi is clear, which is the only case it is used
    res    = OW'(din >> sh);
    hi     = |(MAXW'(din) & clip_mask(OW + int'(sh)));
    // bit sh of {din,0} is din[sh-1], and the appended zero makes sh=0 a no-op
    rbit   = rnd & (|(MAXW'({din, 1'b0}) &
                      (clip_mask(int'(sh)) ^ clip_mask(int'(sh) + 1))));
    sum    = {1'b0, res} + (OW+1)'(rbit);
    dout_d = dout_q;
    sat_d  = sat_q;
    if (en) begin
      sat_d  = hi | sum[OW];
      dout_d = (hi | sum[OW]) ? '1 : sum[OW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      dout_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      sat_q  <= sat_d;
    end
  end

  assign dout = dout_q;
  assign sat  = sat_q;
endmodule

// File: rtl/blpixgain.sv
// Frame-synchronous pixel gain stage: shadow gain regs, stage-1 capture, NCH clip lanes,
// and a per-frame saturated-sample counter.
module blpixgain import blpix_pkg::*; #(
  parameter int NCH = NCH_DEF,
  parameter int IW  = IW_DEF,
  parameter int OW  = OW_DEF,
  parameter int GW  = GW_DEF,
  parameter int CW  = CW_DEF
) (
  input logic        clk,
  input logic        init,
  blpixgain_if.slave bus
);
  localparam int GMAX   = IW - OW;
  localparam int SW     = (GMAX < 1) ? 1 : $clog2(GMAX + 1);
  localparam int STAGES = 2;
  localparam int AW     = CW + PCW + 1;

  logic [GW-1:0]          gsel_act_d, gsel_act_q;
  logic                   rnd_act_d, rnd_act_q;
  logic [STAGES:1]        vld_pipe_d, vld_pipe_q;
  logic [NCH-1:0][IW-1:0] din_d, din_q;
  logic [SW-1:0]          sh_d, sh_q;
  logic                   rnd_d, rnd_q;
  logic [CW-1:0]          acc_d, acc_q, satcnt_d, satcnt_q;
  logic                   satcnt_vld_d, satcnt_vld_q;
  logic [NCH-1:0][OW-1:0] dout_w;
  logic [NCH-1:0]         sat_w;
  logic [PCW-1:0]         inc;
  logic [AW-1:0]          acc_sum;

  // Stage 1 latches the gain in force with the sample so a tv never splits one.
  always_comb begin
    gsel_act_d = bus.tv ? bus.gsel   : gsel_act_q;
    rnd_act_d  = bus.tv ? bus.rnd_en : rnd_act_q;
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], bus.vin};
    din_d      = din_q;
    sh_d       = sh_q;
    rnd_d      = rnd_q;
    if (bus.vin) begin
      din_d = bus.din;
      sh_d  = (int'(gsel_act_q) >= GMAX) ? '0 : SW'(GMAX - int'(gsel_act_q));
      rnd_d = rnd_act_q;
    end
  end

  // On tv the current cycle's clips open the new frame rather than close the old one.
  always_comb begin
    inc          = vld_pipe_q[STAGES] ? popcount(MAXW'(sat_w)) : '0;
    acc_sum      = AW'(bus.tv ? '0 : acc_q) + AW'(inc);
    acc_d        = (|acc_sum[AW-1:CW]) ? '1 : acc_sum[CW-1:0];
    satcnt_d     = bus.tv ? acc_q : satcnt_q;
    satcnt_vld_d = bus.tv;
  end

  always_ff @(posedge clk) begin
    if (init) begin
      gsel_act_q   <= '0;
      rnd_act_q    <= 1'b0;
      vld_pipe_q   <= '0;
      din_q        <= '0;
      sh_q         <= '0;
      rnd_q        <= 1'b0;
      acc_q        <= '0;
      satcnt_q     <= '0;
      satcnt_vld_q <= 1'b0;
    end else begin
      gsel_act_q   <= gsel_act_d;
      rnd_act_q    <= rnd_act_d;
      vld_pipe_q   <= vld_pipe_d;
      din_q        <= din_d;
      sh_q         <= sh_d;
      rnd_q        <= rnd_d;
      acc_q        <= acc_d;
      satcnt_q     <= satcnt_d;
      satcnt_vld_q <= satcnt_vld_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    blpixsat #(.IW(IW), .OW(OW), .SW(SW)) u_sat (
      .clk  (clk),
      .init (init),
      .en   (vld_pipe_q[STAGES-1]),
      .din  (din_q[k]),
      .sh   (sh_q),
      .rnd  (rnd_q),
      .dout (dout_w[k]),
      .sat  (sat_w[k])
    );
  end

  assign bus.vout       = vld_pipe_q[STAGES];
  assign bus.dout       = dout_w;
  assign bus.sat        = sat_w;
  assign bus.gsel_act   = gsel_act_q;
  assign bus.satcnt     = satcnt_q;
  assign bus.satcnt_vld = satcnt_vld_q;
endmodule

// File: tb/tb_blpixgain.sv
// Directed bench for blpixgain: gain/round/clip table plus frame-sync, stats and reset sequences.
module tb_blpixgain;
  import blpix_pkg::*;
  localparam int NCH = 10, IW = 10, OW = 8, GW = 2;

  logic clk = 1'b0;
  logic init;
  int   total = 0, bad = 0;

  always #5 clk = ~clk;

  blpixgain_if #(.NCH(NCH), .IW(IW), .OW(OW), .GW(GW), .CW(16)) b0 ();
  blpixgain_if #(.NCH(NCH), .IW(IW), .OW(OW), .GW(GW), .CW(4))  b1 ();

  assign b1.tv     = b0.tv;
  assign b1.gsel   = b0.gsel;
  assign b1.rnd_en = b0.rnd_en;
  assign b1.vin    = b0.vin;
  assign b1.din    = b0.din;

  blpixgain #(.NCH(NCH), .IW(IW), .OW(OW), .GW(GW), .CW(16)) u0 (.clk(clk), .init(init), .bus(b0));
  blpixgain #(.NCH(NCH), .IW(IW), .OW(OW), .GW(GW), .CW(4))  u1 (.clk(clk), .init(init), .bus(b1));

  typedef struct {
    logic [GW-1:0] g;
    logic          r;
    logic [IW-1:0] d;
    logic [OW-1:0] q;
    logic          s;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [NCH*IW-1:0] mk_din(input logic [IW-1:0] a, input int na,
                                               input logic [IW-1:0] b);
    logic [NCH*IW-1:0] r;
    for (int k = 0; k < NCH; k++) r[k*IW +: IW] = (k < na) ? a : b;
    return r;
  endfunction

  function automatic logic [NCH*OW-1:0] mk_dout(input logic [OW-1:0] a, input int na,
                                                input logic [OW-1:0] b);
    logic [NCH*OW-1:0] r;
    for (int k = 0; k < NCH; k++) r[k*OW +: OW] = (k < na) ? a : b;
    return r;
  endfunction

  function automatic logic [NCH-1:0] mk_sat(input int na);
    logic [NCH-1:0] r;
    for (int k = 0; k < NCH; k++) r[k] = (k < na);
    return r;
  endfunction

  task automatic strobe(input logic [GW-1:0] g, input logic r);
    b0.gsel = g; b0.rnd_en = r; b0.tv = 1'b1;
    tick();
    b0.tv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{2'd0, 1'b0, 10'h3FF, 8'hFF, 1'b0};
    tbl[1]  = '{2'd0, 1'b0, 10'h155, 8'h55, 1'b0};
    tbl[2]  = '{2'd1, 1'b0, 10'h200, 8'hFF, 1'b1};
    tbl[3]  = '{2'd1, 1'b0, 10'h1FE, 8'hFF, 1'b0};
    tbl[4]  = '{2'd2, 1'b0, 10'h100, 8'hFF, 1'b1};
    tbl[5]  = '{2'd2, 1'b0, 10'h0AB, 8'hAB, 1'b0};
    tbl[6]  = '{2'd3, 1'b0, 10'h0AB, 8'hAB, 1'b0};
    tbl[7]  = '{2'd0, 1'b1, 10'h006, 8'h02, 1'b0};
    tbl[8]  = '{2'd0, 1'b1, 10'h3FE, 8'hFF, 1'b1};
    tbl[9]  = '{2'd1, 1'b1, 10'h0FF, 8'h80, 1'b0};
    tbl[10] = '{2'd1, 1'b1, 10'h1FF, 8'hFF, 1'b1};
    tbl[11] = '{2'd2, 1'b1, 10'h0FF, 8'hFF, 1'b0};
    tbl[12] = '{2'd2, 1'b1, 10'h0AB, 8'hAB, 1'b0};

    init = 1'b1;
    b0.tv = 1'b0; b0.gsel = '0; b0.rnd_en = 1'b0; b0.vin = 1'b0; b0.din = '0;
    tick(3);
    chk("rst_vout",     128'(b0.vout),       128'(0));
    chk("rst_dout",     128'(b0.dout),       128'(0));
    chk("rst_sat",      128'(b0.sat),        128'(0));
    chk("rst_gact",     128'(b0.gsel_act),   128'(0));
    chk("rst_satcnt",   128'(b0.satcnt),     128'(0));
    chk("rst_satvld",   128'(b0.satcnt_vld), 128'(0));
    init = 1'b0;
    tick();

    // table: latch gain on tv, scramble the live controls, then push one sample
    for (int i = 0; i < 13; i++) begin
      strobe(tbl[i].g, tbl[i].r);
      b0.gsel = ~tbl[i].g; b0.rnd_en = ~tbl[i].r;
      chk($sformatf("v%0d_gact", i), 128'(b0.gsel_act), 128'(tbl[i].g));
      b0.din = mk_din(tbl[i].d, NCH, tbl[i].d); b0.vin = 1'b1;
      tick();
      b0.vin = 1'b0; b0.din = '0;
      chk($sformatf("v%0d_lat1", i), 128'(b0.vout), 128'(0));
      tick();
      chk($sformatf("v%0d_vout", i), 128'(b0.vout), 128'(1));
      chk($sformatf("v%0d_dout", i), 128'(b0.dout), 128'(mk_dout(tbl[i].q, NCH, tbl[i].q)));
      chk($sformatf("v%0d_sat", i),  128'(b0.sat),  128'(tbl[i].s ? mk_sat(NCH) : mk_sat(0)));
    end

    // gain/round change without tv has no effect
    strobe(2'd0, 1'b0);
    b0.gsel = 2'd2; b0.rnd_en = 1'b1;
    b0.din = mk_din(10'h157, NCH, 10'h157); b0.vin = 1'b1;
    tick();
    b0.vin = 1'b0;
    tick();
    chk("nosync_dout", 128'(b0.dout),     128'(mk_dout(8'h55, NCH, 8'h55)));
    chk("nosync_sat",  128'(b0.sat),      128'(0));
    chk("nosync_gact", 128'(b0.gsel_act), 128'(0));

    // tv at t with continuous vin: sample t old gain, sample t+1 new gain
    b0.gsel = 2'd2; b0.rnd_en = 1'b0; b0.tv = 1'b1;
    b0.din = mk_din(10'h0AB, NCH, 10'h0AB); b0.vin = 1'b1;
    tick();
    b0.tv = 1'b0;
    chk("sync_gact", 128'(b0.gsel_act), 128'(2));
    tick();
    b0.vin = 1'b0;
    chk("sync_old", 128'(b0.dout), 128'(mk_dout(8'h2A, NCH, 8'h2A)));
    tick();
    chk("sync_new", 128'(b0.dout), 128'(mk_dout(8'hAB, NCH, 8'hAB)));
    tick();
    chk("hold_vout", 128'(b0.vout), 128'(0));
    chk("hold_dout", 128'(b0.dout), 128'(mk_dout(8'hAB, NCH, 8'hAB)));
    tick(2);

    // 5 samples x 3 clipping channels
    strobe(2'd1, 1'b0);
    b0.din = mk_din(10'h200, 3, 10'h010); b0.vin = 1'b1;
    tick(5);
    b0.vin = 1'b0;
    tick();
    chk("st_sat",  128'(b0.sat),  128'(mk_sat(3)));
    chk("st_dout", 128'(b0.dout), 128'(mk_dout(8'hFF, 3, 8'h08)));
    chk("st_vld0", 128'(b0.satcnt_vld), 128'(0));
    tick();
    b0.tv = 1'b1;
    tick();
    b0.tv = 1'b0;
    chk("st_cnt",  128'(b0.satcnt),     128'(15));
    chk("st_vld1", 128'(b0.satcnt_vld), 128'(1));
    chk("st_cnt4", 128'(b1.satcnt),     128'(15));
    tick();
    chk("st_vldp", 128'(b0.satcnt_vld), 128'(0));
    chk("st_held", 128'(b0.satcnt),     128'(15));

    // clipping sample coincident with tv belongs to the next frame
    b0.din = mk_din(10'h200, 3, 10'h010); b0.vin = 1'b1;
    tick();
    b0.vin = 1'b0;
    tick();
    b0.tv = 1'b1;
    tick();
    b0.tv = 1'b0;
    chk("co_prev", 128'(b0.satcnt), 128'(0));
    tick(2);
    b0.tv = 1'b1;
    tick();
    b0.tv = 1'b0;
    chk("co_next", 128'(b0.satcnt), 128'(3));

    // 20 clips: wide counter exact, CW=4 counter saturates
    b0.din = mk_din(10'h200, 2, 10'h010); b0.vin = 1'b1;
    tick(10);
    b0.vin = 1'b0;
    tick(3);
    b0.tv = 1'b1;
    tick();
    b0.tv = 1'b0;
    chk("sat16_cnt", 128'(b0.satcnt), 128'(20));
    chk("sat4_cnt",  128'(b1.satcnt), 128'(15));

    // reset mid-frame with samples in flight and a tv that must be ignored
    b0.din = mk_din(10'h200, NCH, 10'h200); b0.vin = 1'b1;
    tick(2);
    b0.vin = 1'b0;
    tick(3);
    b0.vin = 1'b1;
    tick();
    init = 1'b1; b0.tv = 1'b1; b0.gsel = 2'd2; b0.rnd_en = 1'b1;
    tick();
    init = 1'b0; b0.tv = 1'b0; b0.vin = 1'b0;
    chk("ri_vout",   128'(b0.vout),       128'(0));
    chk("ri_dout",   128'(b0.dout),       128'(0));
    chk("ri_sat",    128'(b0.sat),        128'(0));
    chk("ri_gact",   128'(b0.gsel_act),   128'(0));
    chk("ri_satcnt", 128'(b0.satcnt),     128'(0));
    chk("ri_satvld", 128'(b0.satcnt_vld), 128'(0));
    tick();
    chk("ri_vout1", 128'(b0.vout), 128'(0));
    tick();
    chk("ri_vout2", 128'(b0.vout), 128'(0));
    strobe(2'd0, 1'b0);
    chk("ri_cnt",  128'(b0.satcnt),     128'(0));
    chk("ri_vld",  128'(b0.satcnt_vld), 128'(1));
    chk("ri_cnt4", 128'(b1.satcnt),     128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
